// File: rtl/pipe_buffer_pkg.sv
// rtl/pipe_buffer_pkg.sv - shared helpers for valid-ready pipeline buffers
package pipe_buffer_pkg;

  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

  // Explicit wrap compare so non-power-of-two depths stay in range.
  function automatic int unsigned ptr_inc(input int unsigned ptr, input int unsigned limit);
    return (ptr == limit - 1) ? 0 : ptr + 1;
  endfunction

endpackage

// File: rtl/pipe_fifo_buffer.sv
// rtl/pipe_fifo_buffer.sv - registered valid-ready FIFO buffer with occupancy and flush
module pipe_fifo_buffer
  import pipe_buffer_pkg::*;
#(
  parameter int DWIDTH = 8,
  parameter int DEPTH  = 4,
  parameter int CNTW   = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_flush,
  input  logic [DWIDTH-1:0] i_data,
  input  logic              i_valid,
  output logic              o_ready,
  output logic [DWIDTH-1:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [CNTW-1:0]   o_count
);

  localparam int PW = $clog2(DEPTH);

  logic [DWIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]     r_wr_ptr;
  logic [PW-1:0]     r_rd_ptr;
  logic [CNTW-1:0]   r_count;
  logic              r_valid;
  logic              r_ready;

  logic              w_push;
  logic              w_pop;
  logic [CNTW-1:0]   w_count_next;

  assign w_push = i_valid && r_ready;
  assign w_pop  = r_valid && i_ready;

  always_comb begin
    w_count_next = r_count;
    if (w_push && !w_pop) begin
      w_count_next = r_count + CNTW'(1);
    end else if (!w_push && w_pop) begin
      w_count_next = r_count - CNTW'(1);
    end
  end

  // Handshake outputs are loaded from the next count so both sides see only flops.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= 1'b0;
      r_ready  <= 1'b1;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= PW'(ptr_inc(32'(r_wr_ptr), DEPTH));
      end
      if (w_pop) begin
        r_rd_ptr <= PW'(ptr_inc(32'(r_rd_ptr), DEPTH));
      end
      r_count <= w_count_next;
      r_valid <= (w_count_next != '0);
      r_ready <= (w_count_next < CNTW'(DEPTH));
    end
  end

  assign o_data  = r_mem[r_rd_ptr];
  assign o_valid = r_valid;
  assign o_ready = r_ready;
  assign o_count = r_count;

endmodule

// File: tb/tb_pipe_fifo_buffer.sv
// tb/tb_pipe_fifo_buffer.sv - scoreboard bench for pipe_fifo_buffer
module tb_pipe_fifo_buffer;

  localparam int DW = 8;
  localparam int DP = 4;

  logic          clk = 1'b0;
  logic          rstn;
  logic          i_flush;
  logic [DW-1:0] i_data;
  logic          i_valid;
  logic          o_ready;
  logic [DW-1:0] o_data;
  logic          o_valid;
  logic          i_ready;
  logic [2:0]    o_count;

  int checks = 0;
  int errors = 0;

  logic [DW-1:0] sb[$];
  int            m_cnt = 0;
  bit            m_rdy = 1'b0;
  bit            started = 1'b0;

  pipe_fifo_buffer #(.DWIDTH(DW), .DEPTH(DP)) dut (
    .clk     (clk),
    .rstn    (rstn),
    .i_flush (i_flush),
    .i_data  (i_data),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (o_data),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_count (o_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Reference model: occupancy as a plain count, accepted words queued for the monitor.
  always @(posedge clk) begin
    bit push;
    bit pop;
    if (!rstn) begin
      m_cnt = 0;
      m_rdy = 1'b0;
      sb.delete();
    end else if (i_flush) begin
      m_cnt = 0;
      m_rdy = 1'b1;
      sb.delete();
    end else begin
      push = i_valid && m_rdy;
      pop  = (m_cnt > 0) && i_ready;
      if (push) sb.push_back(i_data);
      m_cnt = m_cnt + int'(push) - int'(pop);
      m_rdy = (m_cnt < DP);
    end
    started = 1'b1;
  end

  always @(negedge clk) begin
    if (started) begin
      chk("o_count", 32'(o_count), 32'(m_cnt));
      chk("o_valid", 32'(o_valid), 32'(m_cnt != 0));
      chk("o_ready", 32'(o_ready), 32'(m_rdy));
      if (o_count > 3'(DP)) chk("count_bound", 32'(o_count), 32'(DP));
      if (o_valid === 1'b1) begin
        if (sb.size() == 0) begin
          chk("data_unexpected", 32'(o_valid), 32'd0);
        end else begin
          chk("o_data", 32'(o_data), 32'(sb[0]));
          if (i_ready && rstn && !i_flush) void'(sb.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn = 1'b0; i_flush = 1'b0; i_data = '0; i_valid = 1'b0; i_ready = 1'b0;
    step(); step();
    chk("rst_data", 32'(o_data), 32'h0);
    chk("rst_ready", 32'(o_ready), 32'h0);
    rstn = 1'b1;
    step();
    chk("ready_after_rst", 32'(o_ready), 32'h1);
    step();
    chk("idle_valid", 32'(o_valid), 32'h0);

    for (int i = 0; i < DP; i++) begin
      i_valid = 1'b1; i_data = 8'(8'h11 * (i + 1));
      step();
      chk("fill_count", 32'(o_count), 32'(i + 1));
    end
    i_data = 8'h55;
    step(); step();
    chk("full_ready", 32'(o_ready), 32'h0);
    chk("full_head", 32'(o_data), 32'h11);
    chk("full_count", 32'(o_count), 32'd4);

    i_valid = 1'b0; i_ready = 1'b1;
    for (int i = 0; i < DP; i++) begin
      step();
      if (i == 0) chk("ready_after_pop", 32'(o_ready), 32'h1);
    end
    chk("drain_valid", 32'(o_valid), 32'h0);
    chk("drain_count", 32'(o_count), 32'h0);

    for (int i = 0; i < 20; i++) begin
      i_valid = 1'b1; i_data = 8'(i);
      step();
      chk("stream_count", 32'(o_count), 32'h1);
    end
    i_valid = 1'b0;
    step(); step();

    for (int i = 0; i < 1000; i++) begin
      i_valid = ($urandom_range(0, 99) < 60);
      i_ready = ($urandom_range(0, 99) < 45);
      i_data  = 8'($urandom);
      step();
    end
    i_valid = 1'b0; i_ready = 1'b1;
    repeat (DP + 2) step();
    chk("sb_empty", 32'(sb.size()), 32'h0);

    i_ready = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin i_data = 8'(8'hA0 + i); step(); end
    chk("pre_flush_count", 32'(o_count), 32'd3);
    i_flush = 1'b1; i_data = 8'h66;
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("flush_count", 32'(o_count), 32'h0);
    chk("flush_valid", 32'(o_valid), 32'h0);
    chk("flush_ready", 32'(o_ready), 32'h1);
    i_ready = 1'b1;
    step(); step();
    chk("flush_no_66", 32'(o_valid), 32'h0);

    i_ready = 1'b0; i_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin i_data = 8'(8'hB0 + i); step(); end
    rstn = 1'b0; i_data = 8'h66;
    step();
    chk("rst_mid_ready", 32'(o_ready), 32'h0);
    chk("rst_mid_count", 32'(o_count), 32'h0);
    chk("rst_mid_data", 32'(o_data), 32'h0);
    rstn = 1'b1; i_valid = 1'b0;
    step(); step();
    chk("rst_mid_idle", 32'(o_valid), 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
